// File: rtl/chan_enc_pkg.sv
// Shared types and constants for the channel encoder and its consumers.
package chan_enc_pkg;

    localparam int NUM_CH_MAX = 8;
    localparam int CODE_W     = 4;
    localparam logic [CODE_W-1:0] CODE_OFF = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_OFFER,
        S_DWELL,
        S_GAP,
        S_FIN
    } state_t;

    // Channel codes are 1-based so that 0 can mean "all channels off".
    function automatic logic [CODE_W-1:0] idx_to_code(input logic [CODE_W-1:0] idx);
        return idx + CODE_W'(1);
    endfunction

endpackage

// File: rtl/chan_encoder_if.sv
// Request/handshake bundle between a sequence host, the channel encoder and the channel decoder.
interface chan_encoder_if
    import chan_enc_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DWELL_W = 8
);
    logic               start;
    logic               abort;
    logic [NUM_CH-1:0]  req_mask;
    logic [DWELL_W-1:0] dwell;
    logic [CODE_W-1:0]  bout;
    logic               bvalid;
    logic               bready;
    logic               busy;
    logic               done;

    // master: the encoder, which produces the channel code stream
    modport master (
        input  start, abort, req_mask, dwell, bready,
        output bout, bvalid, busy, done
    );

    // slave: host and decoder side
    modport slave (
        output start, abort, req_mask, dwell, bready,
        input  bout, bvalid, busy, done
    );

endinterface

// File: rtl/chan_prio_enc.sv
// Combinational lowest-set-bit finder: index of the lowest 1 in i_mask, o_found when any bit set.
module chan_prio_enc #(
    parameter  int W  = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  i_mask,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_encoder.sv
// Walks the requested channels lowest-first: offer code, hold for the dwell time, one off cycle, next.
// start->bvalid is 2 cycles; bvalid/bout hold while bready is low; every output is a register.
module chan_encoder
    import chan_enc_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    chan_encoder_if.master bus
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t             r_state;
    state_t             w_nxt;
    logic [NUM_CH-1:0]  r_pending;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx;
    logic               w_found;
    logic               w_abort;

    logic [CODE_W-1:0]  r_bout, w_bout;
    logic               r_bvalid, w_bvalid;
    logic               r_busy, w_busy;
    logic               r_done, w_done;

    assign w_abort = bus.abort && (r_state != S_IDLE);

    chan_prio_enc #(.W(NUM_CH)) u_prio (
        .i_mask  (r_pending),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_nxt = (|bus.req_mask) ? S_SCAN : S_FIN;
            S_SCAN:  w_nxt = w_found ? S_OFFER : S_FIN;
            S_OFFER: if (bus.bready) w_nxt = S_DWELL;
            S_DWELL: if (r_cnt <= DWELL_W'(1)) w_nxt = S_GAP;
            S_GAP:   w_nxt = S_SCAN;
            S_FIN:   w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
        // FIN is already the terminating state, so an abort there just lets it finish
        if (w_abort && r_state != S_FIN) w_nxt = S_FIN;
    end

    always_comb begin
        w_bout = CODE_OFF;
        case (w_nxt)
            S_OFFER: w_bout = (r_state == S_OFFER) ? r_bout : idx_to_code(CODE_W'(w_idx));
            S_DWELL: w_bout = r_bout;
            default: w_bout = CODE_OFF;
        endcase
        w_bvalid = (w_nxt == S_OFFER);
        w_busy   = (w_nxt != S_IDLE);
        w_done   = (w_nxt == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bout   <= CODE_OFF;
            r_bvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_bout   <= w_bout;
            r_bvalid <= w_bvalid;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_dwell   <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else if (w_abort) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && |bus.req_mask) begin
                        r_pending <= bus.req_mask;
                        r_dwell   <= bus.dwell;
                    end
                end
                S_SCAN: r_idx <= w_idx;
                S_OFFER: begin
                    if (bus.bready) begin
                        r_pending <= r_pending & ~(NUM_CH'(1) << r_idx);
                        r_cnt     <= (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
                    end
                end
                // saturates at 1; leaving DWELL is decided on the value 1
                S_DWELL: if (r_cnt > DWELL_W'(1)) r_cnt <= r_cnt - DWELL_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.bout   = r_bout;
    assign bus.bvalid = r_bvalid;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_chan_encoder.sv
// Bench for chan_encoder: expected per-cycle traces are built from the sequence timing rules.
module tb_chan_encoder;
    import chan_enc_pkg::*;

    localparam int MAXC = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   L;

    logic [3:0] e_bout [MAXC];
    bit         e_vld  [MAXC];
    bit         e_busy [MAXC];
    bit         e_done [MAXC];
    bit         brdy   [MAXC];

    chan_encoder_if #(.NUM_CH(8), .DWELL_W(8)) bus ();

    chan_encoder #(.NUM_CH(8), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %0h, expected %0h", tag, c, got, exp);
        end
    endtask

    // 0: bready always high, 1: low during cycles 2..6, 2: random but high at least every 8 cycles
    task automatic fill_brdy(input int mode);
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0:       brdy[i] = 1'b1;
                1:       brdy[i] = !(i >= 2 && i <= 6);
                default: brdy[i] = (i % 8 == 7) || ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    // Cycle 0 is the start cycle; channels are served lowest first.
    task automatic build(input logic [7:0] mask, input int dw);
        int c;
        int d;
        d = (dw == 0) ? 1 : dw;
        for (int i = 0; i < MAXC; i++) begin
            e_bout[i] = 4'd0; e_vld[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
        end
        if (mask == 8'h00) begin
            e_busy[1] = 1'b1; e_done[1] = 1'b1; L = 3;
            return;
        end
        e_busy[1] = 1'b1;
        c = 2;
        for (int ch = 1; ch <= 8; ch++) begin
            if (mask[ch-1]) begin
                while (!brdy[c]) begin
                    e_bout[c] = 4'(ch); e_vld[c] = 1'b1; e_busy[c] = 1'b1; c++;
                end
                e_bout[c] = 4'(ch); e_vld[c] = 1'b1; e_busy[c] = 1'b1;
                for (int j = 1; j <= d; j++) begin
                    e_bout[c+j] = 4'(ch); e_busy[c+j] = 1'b1;
                end
                e_busy[c+d+1] = 1'b1;
                e_busy[c+d+2] = 1'b1;
                c = c + d + 3;
            end
        end
        e_busy[c] = 1'b1; e_done[c] = 1'b1;
        L = c + 2;
    endtask

    task automatic apply(input logic [7:0] mask, input logic [7:0] dw, input int abort_at, input int rst_at);
        logic [3:0] prev;
        prev = 4'd0;
        if (abort_at >= 0) begin
            e_bout[abort_at+1] = 4'd0; e_vld[abort_at+1] = 1'b0;
            e_busy[abort_at+1] = 1'b1; e_done[abort_at+1] = 1'b1;
            e_bout[abort_at+2] = 4'd0; e_vld[abort_at+2] = 1'b0;
            e_busy[abort_at+2] = 1'b0; e_done[abort_at+2] = 1'b0;
            L = abort_at + 3;
        end
        for (int c = 0; c < L; c++) begin
            chk("bout",   c, 8'(bus.bout),   8'(e_bout[c]));
            chk("bvalid", c, 8'(bus.bvalid), 8'(e_vld[c]));
            chk("busy",   c, 8'(bus.busy),   8'(e_busy[c]));
            chk("done",   c, 8'(bus.done),   8'(e_done[c]));
            chk("bout_range", c, 8'(bus.bout <= 4'(NUM_CH_MAX)), 8'd1);
            chk("break_before_make", c, 8'(bus.bout != 0 && prev != 0 && bus.bout != prev), 8'd0);
            prev = bus.bout;
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_bout",   c, 8'(bus.bout),   8'd0);
                chk("rst_bvalid", c, 8'(bus.bvalid), 8'd0);
                chk("rst_busy",   c, 8'(bus.busy),   8'd0);
                chk("rst_done",   c, 8'(bus.done),   8'd0);
                @(negedge clk);
                rst_n = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
                return;
            end
            bus.start    = (c == 0) ? 1'b1 : (e_busy[c] ? 1'($urandom_range(0, 1)) : 1'b0);
            bus.req_mask = (c == 0) ? mask : 8'($urandom);
            bus.dwell    = (c == 0) ? dw   : 8'($urandom);
            bus.bready   = brdy[c];
            // abort in the trailing idle cycle must be ignored
            bus.abort    = (c == abort_at) || (c == L - 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int a;
        int r;
        logic [7:0] m;
        int dw;
        bus.start = 1'b0; bus.abort = 1'b0; bus.req_mask = 8'h00;
        bus.dwell = 8'h00; bus.bready = 1'b0;

        #12;
        chk("reset_bout",   -1, 8'(bus.bout),   8'd0);
        chk("reset_bvalid", -1, 8'(bus.bvalid), 8'd0);
        chk("reset_busy",   -1, 8'(bus.busy),   8'd0);
        chk("reset_done",   -1, 8'(bus.done),   8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_brdy(0); build(8'h05, 3); apply(8'h05, 8'd3, -1, -1);
        fill_brdy(1); build(8'h80, 2); apply(8'h80, 8'd2, -1, -1);
        fill_brdy(0); build(8'h00, 5); apply(8'h00, 8'd5, -1, -1);
        fill_brdy(2); build(8'h93, 0); apply(8'h93, 8'd0, -1, -1);

        fill_brdy(0); build(8'hFF, 3);
        a = -1;
        for (int c = 0; c < L; c++) if (a < 0 && e_bout[c] == 4'd4 && !e_vld[c]) a = c;
        apply(8'hFF, 8'd3, a, -1);
        build(8'hFF, 1); apply(8'hFF, 8'd1, -1, -1);

        build(8'h0A, 4);
        r = -1;
        for (int c = 0; c < L; c++) if (r < 0 && e_bout[c] != 4'd0 && !e_vld[c]) r = c + 1;
        apply(8'h0A, 8'd4, -1, r);
        build(8'h41, 2); apply(8'h41, 8'd2, -1, -1);

        for (int it = 0; it < 24; it++) begin
            m  = 8'($urandom);
            dw = int'($urandom_range(0, 5));
            fill_brdy(2);
            build(m, dw);
            a = -1;
            if (m != 8'h00 && $urandom_range(0, 3) == 0) a = int'($urandom_range(1, L - 3));
            apply(m, 8'(dw), a, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_encoder.md
CHAN_ENCODER -- requirements
Module: chan_encoder

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8, giving the number of stimulation channels.
REQ-002 The block SHALL have parameter DWELL_W, default 8, giving the width of the dwell counter.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: one-cycle request to begin a channel sequence; honoured only in IDLE.
REQ-006 Port abort, input, 1: terminate the sequence immediately.
REQ-007 Port req_mask, input, NUM_CH: channels to stimulate, where bit i is channel i+1; sampled when start is honoured.
REQ-008 Port dwell, input, DWELL_W: number of cycles each channel code is held after acceptance; sampled when start is honoured.
REQ-009 Port bout, output, 4: binary channel code to the one-hot channel decoder.
  - 0 = all channels off.
  - n = channel n (1..8).
REQ-010 Port bvalid, output, 1: bout holds a new channel code awaiting acceptance.
REQ-011 Port bready, input, 1: the consumer accepts bout.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: one-cycle pulse when a sequence completes or is aborted.

Function
REQ-014 The block SHALL implement the states IDLE, SCAN, OFFER, DWELL, GAP and FIN, all registered.
REQ-015 Transitions out of IDLE:
  - start=1 with req_mask nonzero: latch req_mask into pending, latch dwell, go to SCAN.
  - start=1 with req_mask=0: go to FIN.
REQ-016 Transitions out of SCAN:
  - pending nonzero: select the lowest set bit k of pending, go to OFFER.
  - pending zero: go to FIN.
REQ-017 OFFER SHALL drive bout=k+1 and bvalid=1.
  - bout holds stable while bvalid=1 and bready=0.
  - On bvalid&bready, clear bit k of pending and go to DWELL.
REQ-018 DWELL SHALL hold bout=k+1 with bvalid=0 for max(dwell,1) cycles, then go to GAP.
REQ-019 GAP SHALL drive bout=0 for exactly one cycle (break-before-make), then go to SCAN.
REQ-020 FIN SHALL drive bout=0 and done=1 for one cycle, then go to IDLE.
REQ-021 Latency SHALL be fixed:
  - start honoured in cycle 0 gives bvalid=1 in cycle 2.
  - Acceptance in cycle t gives GAP in cycle t+max(dwell,1)+1.
  - The next OFFER follows in cycle t+max(dwell,1)+3.
REQ-022 abort SHALL take priority over all other inputs.
  - abort=1 in any non-IDLE state forces FIN on the next edge, with bout=0, bvalid=0 and pending cleared.
  - abort=1 in IDLE has no effect.
REQ-023 start asserted in any state other than IDLE SHALL be ignored; req_mask and dwell changes outside the honoured start cycle SHALL have no effect.
REQ-024 bout SHALL never take a value above NUM_CH, and SHALL pass through 0 between any two distinct nonzero codes.
REQ-025 Bits of req_mask at or above NUM_CH SHALL NOT exist.
REQ-026 The dwell counter SHALL count down from the latched value, treat 0 as 1, and never wrap.

Reset
REQ-027 rst_n low SHALL asynchronously force the following, regardless of clk:
  - state to IDLE;
  - bout, bvalid, busy and done to 0;
  - pending and the dwell counter to 0.
REQ-028 Reset asserted mid-sequence SHALL drop bout to 0 without waiting for a clock edge.
REQ-029 After rst_n rises, the block SHALL honour start on the first clock edge.

Structure
REQ-030 The shared package chan_enc_pkg SHALL hold:
  - the state enumeration;
  - the constants NUM_CH_MAX=8, CODE_W=4 and CODE_OFF=0.
REQ-031 The lowest-set-bit search SHALL be a purely combinational sub-module, chan_prio_enc (mask in, index and found out), instantiated once.
REQ-032 All outputs SHALL be driven directly from registers.

Verification
REQ-033 Sequence 0x05 with dwell=3 and bready tied high:
  - codes 1 then 3, each held 3 cycles after acceptance;
  - bout=0 one cycle between them;
  - done pulses after the last GAP.
REQ-034 Backpressure: mask 0x80 with bready low for 5 cycles in OFFER:
  - bout=8 and bvalid=1 stay stable throughout;
  - acceptance occurs on the cycle bready rises.
REQ-035 Empty and zero cases:
  - mask 0x00 gives done 1 cycle after start, with bout never nonzero;
  - dwell=0 behaves as dwell=1.
REQ-036 Mask 0xFF with abort raised while in DWELL on code 4:
  - bout=0 and done=1 on the next edge;
  - then IDLE;
  - a subsequent start runs fully.
REQ-037 Reset and start handling:
  - rst_n dropped mid-DWELL clears bout asynchronously;
  - a start pulse while busy changes neither pending nor the code order.
